alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/rvga_types.sv | 22 ++
 rtl/alu.sv | 38 +++
 rtl/alu_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/rvga_types.sv
// Shared RVGA type definitions.
//   rvga_word    : 32-bit datapath word
//   rvga_artop_e : ALU operation selector; alt modifies ADD (subtract)
//                  and SRX (arithmetic shift)
package rvga_types;

  localparam int unsigned rvga_word_w = 32;

  typedef logic [rvga_word_w-1:0] rvga_word;

  typedef enum logic [2:0] {
    RVGA_ADD  = 3'd0,
    RVGA_SLL  = 3'd1,
    RVGA_SLT  = 3'd2,
    RVGA_SLTU = 3'd3,
    RVGA_XOR  = 3'd4,
    RVGA_SRX  = 3'd5,
    RVGA_OR   = 3'd6,
    RVGA_AND  = 3'd7
  } rvga_artop_e;

endpackage

// File: rtl/alu.sv
// Combinational RVGA ALU.
//   op     : operation select
//   a, b   : operands (shift amount is b[4:0])
//   alt    : ADD -> subtract, SRX -> arithmetic right shift
//   result : operation result
module alu
  import rvga_types::*;
(
  input  rvga_artop_e op,
  input  rvga_word    a,
  input  rvga_word    b,
  input  logic        alt,
  output rvga_word    result
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  always_comb begin
    shamt  = b[4:0];
    lt_s   = $signed(a) < $signed(b);
    lt_u   = a < b;
    result = '0;
    unique case (op)
      RVGA_ADD:  result = alt ? (a - b) : (a + b);
      RVGA_SLL:  result = a << shamt;
      RVGA_SLT:  result = {{(rvga_word_w-1){1'b0}}, lt_s};
      RVGA_SLTU: result = {{(rvga_word_w-1){1'b0}}, lt_u};
      RVGA_XOR:  result = a ^ b;
      RVGA_SRX:  result = alt ? rvga_word'($signed(a) >>> shamt) : (a >> shamt);
      RVGA_OR:   result = a | b;
      RVGA_AND:  result = a & b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a single
// output result register.
//   clk, reset           : clock, synchronous active-high reset
//   reqN_v_i/_ready_o    : requester N valid/ready handshake
//   reqN_op_i/_a_i/_b_i/_alt_i : requester N operation fields
//   resp_v_o/_id_o/_data_o, resp_ready_i : result handshake
//   grantN_cnt_o         : saturating count of accepted grants per requester
module alu_arbiter
  import rvga_types::*;
#(
  parameter int unsigned cnt_width_p = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_v_i,
  output logic                   req0_ready_o,
  input  rvga_artop_e            req0_op_i,
  input  rvga_word               req0_a_i,
  input  rvga_word               req0_b_i,
  input  logic                   req0_alt_i,
  input  logic                   req1_v_i,
  output logic                   req1_ready_o,
  input  rvga_artop_e            req1_op_i,
  input  rvga_word               req1_a_i,
  input  rvga_word               req1_b_i,
  input  logic                   req1_alt_i,
  output logic                   resp_v_o,
  output logic                   resp_id_o,
  output rvga_word               resp_data_o,
  input  logic                   resp_ready_i,
  output logic [cnt_width_p-1:0] grant0_cnt_o,
  output logic [cnt_width_p-1:0] grant1_cnt_o
);

  localparam logic [cnt_width_p-1:0] cnt_one = {{(cnt_width_p-1){1'b0}}, 1'b1};

  logic        last_grant;
  logic        can_accept;
  logic        sel;
  logic        accept;
  rvga_artop_e alu_op;
  rvga_word    alu_a;
  rvga_word    alu_b;
  logic        alu_alt;
  rvga_word    alu_result;

  always_comb begin
    can_accept = ~resp_v_o | resp_ready_i;

    // On a tie the requester not granted last wins; otherwise the sole
    // valid requester is selected.
    sel = 1'b0;
    if (req0_v_i && req1_v_i) sel = ~last_grant;
    else if (req1_v_i)        sel = 1'b1;

    req0_ready_o = ~reset & can_accept & req0_v_i & ~sel;
    req1_ready_o = ~reset & can_accept & req1_v_i &  sel;
    accept       = req0_ready_o | req1_ready_o;

    alu_op  = sel ? req1_op_i  : req0_op_i;
    alu_a   = sel ? req1_a_i   : req0_a_i;
    alu_b   = sel ? req1_b_i   : req0_b_i;
    alu_alt = sel ? req1_alt_i : req0_alt_i;
  end

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .alt    (alu_alt),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_v_o     <= 1'b0;
      resp_id_o    <= 1'b0;
      resp_data_o  <= '0;
      last_grant   <= 1'b1;
      grant0_cnt_o <= '0;
      grant1_cnt_o <= '0;
    end else begin
      if (accept) begin
        resp_v_o    <= 1'b1;
        resp_id_o   <= sel;
        resp_data_o <= alu_result;
        last_grant  <= sel;
      end else if (resp_ready_i) begin
        resp_v_o <= 1'b0;
      end
      if (req0_ready_o && (grant0_cnt_o != '1)) grant0_cnt_o <= grant0_cnt_o + cnt_one;
      if (req1_ready_o && (grant1_cnt_o != '1)) grant1_cnt_o <= grant1_cnt_o + cnt_one;
    end
  end

endmodule
